// File: rtl/encoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// encoder_pkg : shared widths, types and Encoder constants
// Rev 1.0 - initial release
// ============================================================================
package encoder_pkg;

  localparam int SLICE_W = 25;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 6;

  // Encoder core constants (5x5 lane state, 24 permutation rounds)
  localparam int ENC_LANES  = 25;
  localparam int ENC_ROUNDS = 24;
  localparam int ENC_SLICES = DEPTH;

  typedef logic [SLICE_W-1:0] slice_t;

  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_PUT = 3'd3,
    ST_STREAM   = 3'd4,
    ST_DONE     = 3'd5
  } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/slice_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// slice_buffer : DEPTH x SLICE_W register file, sync write, async read
// Rev 1.0 - initial release
// ============================================================================
module slice_buffer
  import encoder_pkg::*;
(
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [SLICE_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [SLICE_W-1:0] o_rd_data
);

  slice_t r_mem [DEPTH];

  // Contents intentionally survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/encoder_slice_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// encoder_slice_feeder : buffers one 64-slice state and streams it to the Encoder
// Rev 1.0 - initial release
// ============================================================================
module encoder_slice_feeder
  import encoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               loadEn,
  input  logic [SLICE_W-1:0] loadData,
  output logic               loadReady,
  input  logic               encReady,
  input  logic               encPutInput,
  output logic               encStart,
  output logic [SLICE_W-1:0] encIn,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  feeder_state_e     r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_load_ready;
  logic              r_enc_start;
  logic              r_busy;
  logic              r_done;
  slice_t            r_enc_in;
  logic              w_wr_en;
  slice_t            w_rd_data;

  assign w_wr_en = (r_state == ST_LOAD) && loadEn && !rst;

  slice_buffer u_slice_buffer (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (loadData),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_load_ready <= 1'b1;
      r_enc_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_enc_in     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (loadEn) begin
            if (r_wr_ptr == c_last_addr) begin
              r_wr_ptr     <= '0;
              r_state      <= ST_WAIT_RDY;
              r_load_ready <= 1'b0;
              r_busy       <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        ST_WAIT_RDY: begin
          if (encReady) begin
            r_state     <= ST_START;
            r_enc_start <= 1'b1;
          end
        end
        ST_START: begin
          if (!encReady) begin
            r_state     <= ST_WAIT_PUT;
            r_enc_start <= 1'b0;
          end
        end
        ST_WAIT_PUT: begin
          // r_rd_ptr is always 0 here, so w_rd_data is slice 0
          if (encPutInput) begin
            r_enc_in <= w_rd_data;
            r_rd_ptr <= ADDR_W'(1);
            r_state  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // Pointer wrapped to 0: slice 63 has just had its cycle on encIn
          if (r_rd_ptr == '0) begin
            r_enc_in <= '0;
            r_rd_ptr <= '0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_enc_in <= w_rd_data;
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
        end
        ST_DONE: begin
          r_state      <= ST_LOAD;
          r_load_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state      <= ST_LOAD;
          r_load_ready <= 1'b1;
          r_busy       <= 1'b0;
          r_enc_start  <= 1'b0;
          r_enc_in     <= '0;
        end
      endcase
    end
  end

  assign loadReady = r_load_ready;
  assign encStart  = r_enc_start;
  assign encIn     = r_enc_in;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_encoder_slice_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_encoder_slice_feeder : randomized load/handshake/stream scenarios vs queue model
// Rev 1.0 - initial release
// ============================================================================
module tb_encoder_slice_feeder;
  import encoder_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               loadEn;
  logic [SLICE_W-1:0] loadData;
  logic               loadReady;
  logic               encReady;
  logic               encPutInput;
  logic               encStart;
  logic [SLICE_W-1:0] encIn;
  logic               busy;
  logic               done;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: slices in the order they were accepted
  logic [SLICE_W-1:0] model_q[$];

  always #5 clk = ~clk;

  encoder_slice_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .loadEn      (loadEn),
    .loadData    (loadData),
    .loadReady   (loadReady),
    .encReady    (encReady),
    .encPutInput (encPutInput),
    .encStart    (encStart),
    .encIn       (encIn),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SLICE_W-1:0] pattern(input int mode, input int i);
    case (mode)
      0:       return SLICE_W'(i);
      1:       return 25'h1555555 ^ SLICE_W'(i);
      default: return SLICE_W'($urandom);
    endcase
  endfunction

  task automatic check_idle_after_reset(input string tag);
    chk({tag, "_loadReady"}, loadReady, 1);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_encStart"},  encStart,  0);
    chk({tag, "_encIn"},     encIn,     0);
    chk({tag, "_done"},      done,      0);
  endtask

  task automatic run_case(input int mode, input bit early, input int hold,
                          input bit pulse, input bit garbage, input int abort_at);
    int i;
    model_q.delete();
    encReady    = early;
    encPutInput = 1'b0;
    i = 0;
    while (i < DEPTH) begin
      if ($urandom_range(0, 3) == 0) begin
        loadEn = 1'b0;
        tick();
        chk("load_idle_ready", loadReady, 1);
        chk("load_idle_busy", busy, 0);
      end else begin
        loadEn   = 1'b1;
        loadData = pattern(mode, i);
        model_q.push_back(loadData);
        tick();
        i++;
        if (i < DEPTH) begin
          chk("load_ready", loadReady, 1);
        end else begin
          chk("full_loadReady", loadReady, 0);
          chk("full_busy", busy, 1);
        end
      end
    end

    loadEn   = garbage;
    loadData = 25'h1FFFFFF;
    chk("wait_rdy_start", encStart, 0);
    if (!early) begin
      repeat ($urandom_range(1, 4)) begin
        tick();
        chk("wait_rdy_start_low", encStart, 0);
        chk("wait_rdy_loadReady", loadReady, 0);
      end
    end
    encReady = 1'b1;
    tick();
    chk("start_high", encStart, 1);
    for (int h = 1; h < hold; h++) begin
      tick();
      chk("start_held", encStart, 1);
    end
    encReady = 1'b0;
    tick();
    chk("start_low", encStart, 0);
    chk("wait_put_encIn", encIn, 0);
    chk("wait_put_busy", busy, 1);
    repeat ($urandom_range(0, 4)) begin
      tick();
      chk("wait_put_idle_encIn", encIn, 0);
      chk("wait_put_idle_start", encStart, 0);
    end

    chk("put_cycle_encIn", encIn, 0);
    encPutInput = 1'b1;
    tick();
    if (pulse) encPutInput = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("slice%0d", k), encIn, model_q[k]);
      chk("stream_busy", busy, 1);
      chk("stream_done", done, 0);
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        loadEn      = 1'b0;
        encPutInput = 1'b0;
        check_idle_after_reset("abort");
        return;
      end
      if (k < DEPTH - 1) tick();
    end

    encPutInput = 1'b0;
    tick();
    chk("done_pulse", done, 1);
    chk("done_encIn", encIn, 0);
    chk("done_busy", busy, 1);
    chk("done_loadReady", loadReady, 0);
    tick();
    loadEn = 1'b0;
    chk("post_done", done, 0);
    chk("post_loadReady", loadReady, 1);
    chk("post_busy", busy, 0);
    chk("post_encIn", encIn, 0);
  endtask

  initial begin
    rst         = 1'b1;
    loadEn      = 1'b0;
    loadData    = '0;
    encReady    = 1'b0;
    encPutInput = 1'b0;
    tick();
    tick();
    check_idle_after_reset("reset");
    rst = 1'b0;

    run_case(0, 1'b1, 3, 1'b0, 1'b0, -1);
    run_case(1, 1'b0, int'($urandom_range(1, 4)), 1'b1, 1'b1, -1);
    run_case(2, 1'b1, 2, 1'b0, 1'b1, 20);
    run_case(0, 1'b0, 1, 1'b1, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      run_case(2, 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
